// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a small 4-bit ALU with a 4-cycle restoring divider.
// Define ALU_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority.
module alu_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [3:0] req_a0,
    input  logic [3:0] req_b0,
    input  logic [1:0] req_s0,
    input  logic [3:0] req_a1,
    input  logic [3:0] req_b1,
    input  logic [1:0] req_s1,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [7:0] rsp_y,
    output logic       rsp_err,
    output logic       busy
);

    // state | meaning
    // IDLE  | waiting for a request, req_ready may be asserted
    // EXEC  | single-cycle add/sub/mul
    // DIV   | restoring divide, one quotient bit per cycle
    // DONE  | result presented until rsp_ready
    typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;

    state_t     state;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [1:0] op_s;
    logic       op_id;
    logic [1:0] div_cnt;
    logic [3:0] div_rem;
    logic [3:0] div_quo;
    logic [1:0] grant;
    logic       accept;
    logic       sel;
    logic [7:0] exec_y;
    logic [4:0] rem_sh;
    logic       rem_ge;
    logic [4:0] rem_nx;
    logic [3:0] quo_nx;

`ifdef ALU_ARB_RR_EN
    logic last_grant;

    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11)
            grant = last_grant ? 2'b01 : 2'b10;
    end
`else
    always_comb begin
        grant = 2'b00;
        if (req_valid[0])
            grant = 2'b01;
        else if (req_valid[1])
            grant = 2'b10;
    end
`endif

    assign req_ready = (state == IDLE && !rst) ? grant : 2'b00;
    assign accept    = |req_ready;
    assign sel       = req_ready[1];
    assign busy      = (state != IDLE);

    always_comb begin
        exec_y = 8'h00;
        case (op_s)
            2'b00:   exec_y = {3'b000, {1'b0, op_a} + {1'b0, op_b}};
            2'b01:   exec_y = {4'h0, op_a} - {4'h0, op_b};
            2'b10:   exec_y = {4'h0, op_a} * {4'h0, op_b};
            default: exec_y = 8'h00;
        endcase
    end

    // Dividend bits shift out of div_quo's top while quotient bits shift in at the bottom.
    always_comb begin
        rem_sh = {div_rem, div_quo[3]};
        rem_ge = (rem_sh >= {1'b0, op_b});
        rem_nx = rem_ge ? (rem_sh - {1'b0, op_b}) : rem_sh;
        quo_nx = {div_quo[2:0], rem_ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_y     <= 8'h00;
            rsp_id    <= 1'b0;
            rsp_err   <= 1'b0;
            div_cnt   <= 2'd0;
            div_rem   <= 4'h0;
            div_quo   <= 4'h0;
            op_a      <= 4'h0;
            op_b      <= 4'h0;
            op_s      <= 2'b00;
            op_id     <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_grant <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a    <= sel ? req_a1 : req_a0;
                        op_b    <= sel ? req_b1 : req_b0;
                        op_s    <= sel ? req_s1 : req_s0;
                        op_id   <= sel;
                        div_cnt <= 2'd0;
                        div_rem <= 4'h0;
                        div_quo <= sel ? req_a1 : req_a0;
`ifdef ALU_ARB_RR_EN
                        last_grant <= sel;
`endif
                        if ((sel ? req_s1 : req_s0) == 2'b11)
                            state <= DIV;
                        else
                            state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y     <= exec_y;
                    rsp_err   <= 1'b0;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= DONE;
                end
                DIV: begin
                    div_rem <= rem_nx[3:0];
                    div_quo <= quo_nx;
                    div_cnt <= div_cnt + 2'd1;
                    if (div_cnt == 2'd3) begin
                        rsp_y     <= (op_b == 4'h0) ? 8'h00 : {4'h0, quo_nx};
                        rsp_err   <= (op_b == 4'h0);
                        rsp_id    <= op_id;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; honours ALU_ARB_RR_EN for the contention case.
module tb_alu_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [3:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0] req_s0, req_s1;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [7:0] rsp_y;
    logic       rsp_err;
    logic       busy;

    int total = 0;
    int bad   = 0;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_s0(req_s0),
        .req_a1(req_a1), .req_b1(req_b1), .req_s1(req_s1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_err(rsp_err), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Waits from the cycle after accept until rsp_valid; lat counts cycles from the accept cycle.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 25) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_req(input int id, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] s, input logic [7:0] ey, input logic eerr,
                          input int elat);
        logic [1:0] erdy;
        int lat;
        erdy = (id == 0) ? 2'b01 : 2'b10;
        if (id == 0) begin req_a0 = a; req_b0 = b; req_s0 = s; end
        else         begin req_a1 = a; req_b1 = b; req_s1 = s; end
        req_valid = erdy;
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== erdy) begin bad++; $display("FAIL req_ready id=%0d got=%b exp=%b", id, req_ready, erdy); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        req_a0 = ~a; req_b0 = ~b; req_s0 = ~s;
        req_a1 = ~a; req_b1 = ~b; req_s1 = ~s;
        wait_rsp(lat);
        total++;
        if (lat !== elat) begin bad++; $display("FAIL latency a=%0d b=%0d s=%0d got=%0d exp=%0d", a, b, s, lat, elat); end
        total++;
        if (rsp_y !== ey) begin bad++; $display("FAIL rsp_y a=%0d b=%0d s=%0d got=%h exp=%h", a, b, s, rsp_y, ey); end
        total++;
        if (rsp_id !== id[0]) begin bad++; $display("FAIL rsp_id got=%b exp=%0d", rsp_id, id); end
        total++;
        if (rsp_err !== eerr) begin bad++; $display("FAIL rsp_err a=%0d b=%0d s=%0d got=%b exp=%b", a, b, s, rsp_err, eerr); end
        @(posedge clk);
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL back_to_idle rsp_valid=%b busy=%b exp 0/0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        total++;
        if ({rsp_valid, rsp_id, rsp_err, busy, rsp_y} !== 12'h000) begin
            bad++; $display("FAIL reset_outputs valid=%b id=%b err=%b busy=%b y=%h exp all 0",
                            rsp_valid, rsp_id, rsp_err, busy, rsp_y);
        end
        req_valid = 2'b00;
        rst = 1'b0;
    endtask

    task automatic test_ops();
        do_req(0, 4'd1,  4'd3,  2'b00, 8'h04, 1'b0, 2);
        do_req(1, 4'd3,  4'd1,  2'b01, 8'h02, 1'b0, 2);
        do_req(1, 4'd1,  4'd3,  2'b01, 8'hFE, 1'b0, 2);
        do_req(1, 4'd4,  4'd2,  2'b10, 8'h08, 1'b0, 2);
        do_req(1, 4'd15, 4'd15, 2'b10, 8'hE1, 1'b0, 2);
        do_req(0, 4'd15, 4'd15, 2'b00, 8'h1E, 1'b0, 2);
    endtask

    task automatic test_div();
        do_req(0, 4'd2,  4'd1, 2'b11, 8'h02, 1'b0, 5);
        do_req(0, 4'd15, 4'd4, 2'b11, 8'h03, 1'b0, 5);
        do_req(0, 4'd7,  4'd0, 2'b11, 8'h00, 1'b1, 5);
        do_req(1, 4'd13, 4'd3, 2'b11, 8'h04, 1'b0, 5);
    endtask

    task automatic test_backpressure();
        int lat;
        int held_bad;
        req_a1 = 4'd5; req_b1 = 4'd6; req_s1 = 2'b00;
        req_valid = 2'b10;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        wait_rsp(lat);
        total++;
        if (lat !== 2 || rsp_y !== 8'h0B || rsp_id !== 1'b1) begin
            bad++; $display("FAIL bp_result lat=%0d y=%h id=%b exp 2/0b/1", lat, rsp_y, rsp_id);
        end
        req_valid = 2'b11;
        held_bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_y !== 8'h0B || rsp_id !== 1'b1 ||
                req_ready !== 2'b00 || busy !== 1'b1) held_bad++;
        end
        total++;
        if (held_bad != 0) begin bad++; $display("FAIL bp_hold bad_cycles=%0d exp=0", held_bad); end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL bp_release rsp_valid=%b busy=%b exp 0/0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset_mid_div();
        int seen;
        req_a0 = 4'd9; req_b0 = 4'd2; req_s0 = 2'b11;
        req_valid = 2'b01;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        total++;
        if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({rsp_valid, rsp_id, rsp_err, busy, rsp_y} !== 12'h000) begin
            bad++; $display("FAIL rst_mid_outputs valid=%b id=%b err=%b busy=%b y=%h exp all 0",
                            rsp_valid, rsp_id, rsp_err, busy, rsp_y);
        end
        rst = 1'b0;
        req_valid = 2'b00;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL rst_abandon rsp_valid_cycles=%0d exp=0", seen); end
        do_req(1, 4'd9, 4'd2, 2'b11, 8'h04, 1'b0, 5);
    endtask

    task automatic test_contention();
        int exp_seq[8];
        int n0, n1, w, lat;
        logic [1:0] erdy;
        logic [7:0] ey;
`ifdef ALU_ARB_RR_EN
        exp_seq = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
        exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        n0 = 0; n1 = 0;
        req_a0 = 4'd1; req_b0 = 4'd0; req_s0 = 2'b00;
        req_a1 = 4'd1; req_b1 = 4'd8; req_s1 = 2'b00;
        for (int k = 0; k < 8; k++) begin
            w = exp_seq[k];
            erdy = (w == 0) ? 2'b01 : 2'b10;
            req_valid = {n1 < 4, n0 < 4};
            #1;
            total++;
            if (req_ready !== erdy) begin bad++; $display("FAIL arb_grant k=%0d got=%b exp=%b", k, req_ready, erdy); end
            @(posedge clk);
            @(negedge clk);
            if (w == 0) begin n0++; ey = 8'(n0);     req_a0 = 4'(n0 + 1); end
            else        begin n1++; ey = 8'(8 + n1); req_a1 = 4'(n1 + 1); end
            req_valid = {n1 < 4, n0 < 4};
            #1;
            total++;
            if (req_ready !== 2'b00) begin bad++; $display("FAIL arb_holdoff k=%0d got=%b exp=00", k, req_ready); end
            wait_rsp(lat);
            total++;
            if (lat !== 2 || rsp_id !== w[0] || rsp_y !== ey) begin
                bad++; $display("FAIL arb_rsp k=%0d lat=%0d id=%b y=%h exp 2/%0d/%h", k, lat, rsp_id, rsp_y, w, ey);
            end
            @(posedge clk);
            @(negedge clk);
        end
        req_valid = 2'b00;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        req_a0 = 4'h0; req_b0 = 4'h0; req_s0 = 2'b00;
        req_a1 = 4'h0; req_b1 = 4'h0; req_s1 = 2'b00;
        @(negedge clk);
        test_reset();
        test_ops();
        test_div();
        test_backpressure();
        test_reset_mid_div();
        test_contention();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  2  per-requester request strobe; bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept; a request is taken on a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-006 req_a0, req_b0  input  4 each  requester 0 operands.
REQ-007 req_s0  input  2  requester 0 opcode: 00 add, 01 sub, 10 mul, 11 div.
REQ-008 req_a1, req_b1, req_s1  input  4/4/2  requester 1 operands and opcode, same encoding.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts the result when rsp_valid and rsp_ready are both 1.
REQ-011 rsp_id  output  1  index of the requester that owns the result.
REQ-012 rsp_y  output  8  result.
REQ-013 rsp_err  output  1  1 = divide by zero.
REQ-014 busy  output  1  1 in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC, DIV and DONE.
REQ-016 req_ready SHALL be nonzero only in IDLE, with at most one bit set, and only for a requester whose req_valid is 1.
REQ-017 In IDLE, on accept: latch a, b, s and id; go to EXEC when s != 11 and to DIV when s == 11, with the divide counter cleared.
REQ-018 EXEC SHALL last 1 cycle, register rsp_y and go to DONE, so rsp_valid rises 2 cycles after the accept cycle.
REQ-019 DIV SHALL run a restoring divider, 1 quotient bit per cycle, for exactly 4 cycles, then go to DONE, so rsp_valid rises 5 cycles after the accept cycle.
REQ-020 Result widths:
  - add: zero-extended 5-bit sum.
  - sub: 8-bit two's-complement difference of the zero-extended operands (1-3 = 8'hFE).
  - mul: 8-bit product.
  - div: 4-bit quotient zero-extended, remainder discarded.
REQ-021 Divide by zero (b == 0, s == 11): still 4 DIV cycles; rsp_y = 8'h00 and rsp_err = 1. rsp_err SHALL be 0 for all other results.
REQ-022 In DONE: rsp_valid = 1 and rsp_y, rsp_id, rsp_err are held stable until rsp_ready = 1; on that handshake go to IDLE. A new accept is possible in the next cycle.
REQ-023 Outside DONE, rsp_valid SHALL be 0. rsp_y, rsp_id and rsp_err SHALL hold their last values.
REQ-024 Requester inputs are sampled only in the accept cycle. After accept, changes to them SHALL have no effect.
REQ-025 Arbitration, default: fixed priority, requester 0 wins when both are valid.
REQ-026 A requester not granted SHALL be held off (req_ready = 0) and keep its request pending; the arbiter SHALL never drop or merge requests.

Reset
REQ-027 When rst = 1 at a clock edge, the block SHALL:
  - go to IDLE;
  - clear rsp_valid, rsp_y, rsp_id, rsp_err, busy and the divide counter;
  - set the round-robin pointer to "last grant = requester 1".
REQ-028 Reset mid-operation (EXEC, DIV or DONE) SHALL abandon the transaction with no rsp_valid pulse.
REQ-029 While rst = 1, req_ready SHALL be 00.

Configuration
REQ-030 Macro ALU_ARB_RR_EN defined: round-robin arbitration.
  - When both requesters are valid in IDLE, the one not granted last wins.
  - The pointer updates on every accept.
  - After reset, requester 0 wins the first contention.
REQ-031 ALU_ARB_RR_EN undefined: fixed priority per REQ-025, with no pointer register.

Verification
REQ-032 Requester 0 sends a=1, b=3, s=00, rsp_ready held 1 -> rsp_valid 2 cycles after accept, rsp_y=8'h04, rsp_id=0, rsp_err=0.
REQ-033 Requester 1 sends a=3, b=1, s=01, then a=1, b=3, s=01 -> rsp_y=8'h02, then 8'hFE; a=4, b=2, s=10 -> 8'h08; a=15, b=15, s=10 -> 8'hE1.
REQ-034 Divide cases, each -> rsp_valid 5 cycles after accept:
  - a=2, b=1, s=11 -> rsp_y=8'h02.
  - a=15, b=4, s=11 -> 8'h03.
  - a=7, b=0, s=11 -> 8'h00, rsp_err=1.
REQ-035 Both requesters valid continuously, 4 adds each:
  - ALU_ARB_RR_EN defined -> rsp_id sequence 0,1,0,1,...
  - undefined -> 0,0,0,0, then requester 1.
  - No request is lost in either case.
REQ-036 Backpressure: rsp_ready=0 for 6 cycles in DONE -> rsp_valid, rsp_y and rsp_id are held constant, req_ready=00 and busy=1. Release -> handshake, then IDLE.
REQ-037 rst pulsed in the 2nd DIV cycle of a=9, b=2 -> no rsp_valid, all outputs 0, next request serviced normally.
